// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue queue slice.
// Holds the default operand/command widths and the packet width. It also holds
// the bit offsets of the fields in a command packet, the multiply command codes
// that force bubbles, and the issue FSM state encoding.
// Packet layout (LSB first): IN_VALID[1:0], MODE, CIN, CMD, OPB, OPA.
package alu_pkg;

  localparam int ALU_DATA_WIDTH = 8;
  localparam int ALU_CMD_WIDTH  = 4;
  localparam int PKT_W          = 2*ALU_DATA_WIDTH + ALU_CMD_WIDTH + 4;

  // Width-independent field offsets; OPB/OPA offsets follow CMD.
  localparam int FLD_IV_LSB  = 0;
  localparam int FLD_MODE    = 2;
  localparam int FLD_CIN     = 3;
  localparam int FLD_CMD_LSB = 4;

  localparam logic [3:0] CMD_MUL_INC = 4'd9;
  localparam logic [3:0] CMD_MUL_SHL = 4'd10;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } iq_state_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO for the ALU issue queue.
// Ports:
//   CLK, RESET_N   clock, asynchronous active-low reset
//   flush          synchronous clear of pointers and level (wins over push/pop)
//   push, wdata    write one packet at the tail
//   pop, rdata     head packet (combinational read), popped at the edge
//   level          occupancy, one bit wider than the pointers
//   full, empty    level == DEPTH / level == 0
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int PKT_WIDTH = PKT_W,
  parameter int DEPTH     = 4
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   flush,
  input  logic                   push,
  input  logic [PKT_WIDTH-1:0]   wdata,
  input  logic                   pop,
  output logic [PKT_WIDTH-1:0]   rdata,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [PKT_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]        wptr;
  logic [AW-1:0]        rptr;

  // Storage carries no reset; only pointers and level are control state.
  always_ff @(posedge CLK) begin
    if (push) mem[wptr] <= wdata;
  end

  // Pointers wrap naturally; level tells full from empty.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  assign rdata = mem[rptr];
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);

endmodule

// File: rtl/alu_issue_queue.sv
// ALU issue queue: buffers packed ALU commands from a valid/ready upstream and
// issues at most one per cycle onto registered ALU input signals. After a
// multiply (MODE=1, CMD 9 or 10) it inserts MUL_LAT bubble cycles.
// Optional feature macro ISSUE_CNT_EN adds a 16-bit wrapping issue counter.
// Ports:
//   CLK, RESET_N        clock, asynchronous active-low reset
//   S_VALID/S_READY     upstream handshake, S_DATA packet
//   FLUSH               synchronous clear of queue, stall and issue
//   ALU_CE              ALU clock enable (high from first edge after reset)
//   ALU_OPA/OPB/CMD/CIN/MODE/IN_VALID  registered ALU inputs; IN_VALID=00 is a bubble
//   ISSUE_CNT           issue count (only with ISSUE_CNT_EN)
//   LEVEL               queue occupancy
module alu_issue_queue
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = ALU_DATA_WIDTH,
  parameter int CMD_WIDTH  = ALU_CMD_WIDTH,
  parameter int DEPTH      = 4,
  parameter int MUL_LAT    = 2
) (
  input  logic                            CLK,
  input  logic                            RESET_N,
  input  logic                            S_VALID,
  output logic                            S_READY,
  input  logic [2*DATA_WIDTH+CMD_WIDTH+3:0] S_DATA,
  input  logic                            FLUSH,
  output logic                            ALU_CE,
  output logic [DATA_WIDTH-1:0]           ALU_OPA,
  output logic [DATA_WIDTH-1:0]           ALU_OPB,
  output logic [CMD_WIDTH-1:0]            ALU_CMD,
  output logic                            ALU_CIN,
  output logic                            ALU_MODE,
  output logic [1:0]                      ALU_IN_VALID,
`ifdef ISSUE_CNT_EN
  output logic [15:0]                     ISSUE_CNT,
`endif
  output logic [$clog2(DEPTH):0]          LEVEL
);

  localparam int PW      = 2*DATA_WIDTH + CMD_WIDTH + 4;
  localparam int OPB_LSB = FLD_CMD_LSB + CMD_WIDTH;
  localparam int OPA_LSB = OPB_LSB + DATA_WIDTH;

  iq_state_e      state_q, state_d;
  logic [2:0]     stall_cnt_q, stall_cnt_d;
  logic [PW-1:0]  head;
  logic           full, empty;
  logic           push, issue, is_mul;
  logic [CMD_WIDTH-1:0] head_cmd;

  // ALU_CE doubles as the "out of reset" flag, keeping S_READY low in reset.
  assign S_READY = ALU_CE && !full && !FLUSH;
  assign push    = S_VALID && S_READY;
  assign issue   = (state_q == IDLE) && !empty && !FLUSH;

  assign head_cmd = head[FLD_CMD_LSB +: CMD_WIDTH];
  assign is_mul   = head[FLD_MODE] &&
                    ((head_cmd == CMD_WIDTH'(CMD_MUL_INC)) ||
                     (head_cmd == CMD_WIDTH'(CMD_MUL_SHL)));

  alu_cmd_fifo #(
    .PKT_WIDTH (PW),
    .DEPTH     (DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .flush   (FLUSH),
    .push    (push),
    .wdata   (S_DATA),
    .pop     (issue),
    .rdata   (head),
    .level   (LEVEL),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // STALL returns to IDLE on the edge where the count is already zero, so a
  // multiply is followed by exactly MUL_LAT bubbles.
  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    if (FLUSH) begin
      state_d     = IDLE;
      stall_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (issue && is_mul && (MUL_LAT > 0)) begin
            state_d     = STALL;
            stall_cnt_d = 3'(MUL_LAT - 1);
          end
        end
        STALL: begin
          if (stall_cnt_q == 3'd0) state_d = IDLE;
          else                     stall_cnt_d = stall_cnt_q - 3'd1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Issue stage: operand fields hold on bubbles, only IN_VALID drops to 00.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ALU_CE       <= 1'b0;
      ALU_OPA      <= '0;
      ALU_OPB      <= '0;
      ALU_CMD      <= '0;
      ALU_CIN      <= 1'b0;
      ALU_MODE     <= 1'b0;
      ALU_IN_VALID <= 2'b00;
    end else begin
      ALU_CE <= 1'b1;
      if (issue) begin
        ALU_OPA      <= head[OPA_LSB +: DATA_WIDTH];
        ALU_OPB      <= head[OPB_LSB +: DATA_WIDTH];
        ALU_CMD      <= head_cmd;
        ALU_CIN      <= head[FLD_CIN];
        ALU_MODE     <= head[FLD_MODE];
        ALU_IN_VALID <= head[FLD_IV_LSB +: 2];
      end else begin
        ALU_IN_VALID <= 2'b00;
      end
    end
  end

`ifdef ISSUE_CNT_EN
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)   ISSUE_CNT <= '0;
    else if (FLUSH) ISSUE_CNT <= '0;
    else if (issue) ISSUE_CNT <= ISSUE_CNT + 16'd1;
  end
`endif

endmodule

// File: tb/tb_alu_issue_queue.sv
module tb_alu_issue_queue;

  localparam int MUL_LAT = 2;

  logic        CLK;
  logic        RESET_N;
  logic        S_VALID;
  logic        S_READY;
  logic [23:0] S_DATA;
  logic        FLUSH;
  logic        ALU_CE;
  logic [7:0]  ALU_OPA;
  logic [7:0]  ALU_OPB;
  logic [3:0]  ALU_CMD;
  logic        ALU_CIN;
  logic        ALU_MODE;
  logic [1:0]  ALU_IN_VALID;
  logic [2:0]  LEVEL;
`ifdef ISSUE_CNT_EN
  logic [15:0] ISSUE_CNT;
`endif

  int checks = 0;
  int errors = 0;
  int n_push = 0;
  logic [23:0] sb[$];
  logic [23:0] mon_exp, mon_got;

  alu_issue_queue #(
    .DATA_WIDTH (8),
    .CMD_WIDTH  (4),
    .DEPTH      (4),
    .MUL_LAT    (MUL_LAT)
  ) dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .S_VALID      (S_VALID),
    .S_READY      (S_READY),
    .S_DATA       (S_DATA),
    .FLUSH        (FLUSH),
    .ALU_CE       (ALU_CE),
    .ALU_OPA      (ALU_OPA),
    .ALU_OPB      (ALU_OPB),
    .ALU_CMD      (ALU_CMD),
    .ALU_CIN      (ALU_CIN),
    .ALU_MODE     (ALU_MODE),
    .ALU_IN_VALID (ALU_IN_VALID),
`ifdef ISSUE_CNT_EN
    .ISSUE_CNT    (ISSUE_CNT),
`endif
    .LEVEL        (LEVEL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [23:0] mk(input logic [7:0] a, input logic [7:0] b,
                                     input logic [3:0] c, input logic ci,
                                     input logic md, input logic [1:0] iv);
    return {a, b, c, ci, md, iv};
  endfunction

  // Scoreboard producer: every accepted packet is expected to issue in order.
  always @(posedge CLK) begin
    if (RESET_N === 1'b1 && S_VALID === 1'b1 && S_READY === 1'b1) begin
      sb.push_back(S_DATA);
      n_push++;
    end
  end

  // Scoreboard consumer: each non-bubble output is one issue.
  always @(negedge CLK) begin
    if (RESET_N === 1'b1 && ALU_IN_VALID !== 2'b00) begin
      mon_got = {ALU_OPA, ALU_OPB, ALU_CMD, ALU_CIN, ALU_MODE, ALU_IN_VALID};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL issue_unexpected: got %h, required no issue", mon_got);
      end else begin
        mon_exp = sb.pop_front();
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL issue_order: got %h, required %h", mon_got, mon_exp);
        end
      end
    end
  end

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (sb.size() == 0 && LEVEL == 3'd0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (MUL_LAT + 1) @(negedge CLK);
  endtask

  task automatic test_reset();
    RESET_N = 1'b1; S_VALID = 1'b0; FLUSH = 1'b0; S_DATA = '0;
    #2 RESET_N = 1'b0;
    #1;
    checks++;
    if ({ALU_CE, ALU_OPA, ALU_OPB, ALU_CMD, ALU_CIN, ALU_MODE, ALU_IN_VALID} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, required 0",
               {ALU_CE, ALU_OPA, ALU_OPB, ALU_CMD, ALU_CIN, ALU_MODE, ALU_IN_VALID});
    end
    checks++;
    if (S_READY !== 1'b0 || LEVEL !== 3'd0) begin
      errors++;
      $display("FAIL reset_ready_level: got ready=%b level=%0d, required 0/0", S_READY, LEVEL);
    end
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    checks++;
    if (ALU_CE !== 1'b1 || S_READY !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: got ce=%b ready=%b, required 1/1", ALU_CE, S_READY);
    end
  endtask

  task automatic test_single();
    @(negedge CLK);
    S_VALID = 1'b1; S_DATA = mk(8'h05, 8'h03, 4'd0, 1'b0, 1'b1, 2'b11);
    @(negedge CLK);
    S_VALID = 1'b0;
    checks++;
    if (LEVEL !== 3'd1 || ALU_IN_VALID !== 2'b00) begin
      errors++;
      $display("FAIL single_accept: got level=%0d iv=%b, required 1/00", LEVEL, ALU_IN_VALID);
    end
    @(negedge CLK);
    checks++;
    if (ALU_OPA !== 8'h05 || ALU_OPB !== 8'h03 || ALU_IN_VALID !== 2'b11 || LEVEL !== 3'd0) begin
      errors++;
      $display("FAIL single_issue: got opa=%h opb=%h iv=%b level=%0d, required 05/03/11/0",
               ALU_OPA, ALU_OPB, ALU_IN_VALID, LEVEL);
    end
    @(negedge CLK);
    checks++;
    if (ALU_IN_VALID !== 2'b00 || ALU_OPA !== 8'h05 || LEVEL !== 3'd0) begin
      errors++;
      $display("FAIL single_bubble: got iv=%b opa=%h level=%0d, required 00/05/0",
               ALU_IN_VALID, ALU_OPA, LEVEL);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (i >= 2) begin
        checks++;
        if (ALU_IN_VALID === 2'b00) begin
          errors++;
          $display("FAIL b2b_slot%0d: got iv=00, required an issue", i);
        end
      end
      if (i < 4) begin
        S_VALID = 1'b1;
        S_DATA  = mk(8'($urandom), 8'($urandom), 4'($urandom_range(0, 8)),
                     1'($urandom), 1'($urandom), 2'($urandom_range(1, 3)));
      end else begin
        S_VALID = 1'b0;
      end
    end
    @(negedge CLK);
    checks++;
    if (ALU_IN_VALID !== 2'b00 || LEVEL !== 3'd0) begin
      errors++;
      $display("FAIL b2b_end: got iv=%b level=%0d, required 00/0", ALU_IN_VALID, LEVEL);
    end
  endtask

  task automatic test_mul_bubble();
    for (int v = 0; v < 2; v++) begin
      @(negedge CLK);
      S_VALID = 1'b1; S_DATA = mk(8'h04, 8'h06, 4'(9 + v), 1'b0, 1'b1, 2'b11);
      @(negedge CLK);
      S_DATA = mk(8'h10, 8'h20, 4'd0, 1'b0, 1'b1, 2'b11);
      @(negedge CLK);
      S_VALID = 1'b0;
      checks++;
      if (ALU_IN_VALID !== 2'b11 || ALU_CMD !== 4'(9 + v) || ALU_OPA !== 8'h04) begin
        errors++;
        $display("FAIL mul_issue: got iv=%b cmd=%0d opa=%h, required 11/%0d/04",
                 ALU_IN_VALID, ALU_CMD, ALU_OPA, 9 + v);
      end
      for (int b = 1; b <= MUL_LAT; b++) begin
        @(negedge CLK);
        checks++;
        if (ALU_IN_VALID !== 2'b00) begin
          errors++;
          $display("FAIL mul_bubble_t%0d: got iv=%b, required 00", b, ALU_IN_VALID);
        end
      end
      @(negedge CLK);
      checks++;
      if (ALU_IN_VALID !== 2'b11 || ALU_CMD !== 4'd0 || ALU_OPA !== 8'h10) begin
        errors++;
        $display("FAIL mul_next: got iv=%b cmd=%0d opa=%h, required 11/0/10",
                 ALU_IN_VALID, ALU_CMD, ALU_OPA);
      end
    end
    // A logical op with a multiply opcode must not stall.
    @(negedge CLK);
    S_VALID = 1'b1; S_DATA = mk(8'h0F, 8'hF0, 4'd9, 1'b0, 1'b0, 2'b11);
    @(negedge CLK);
    S_DATA = mk(8'h11, 8'h22, 4'd0, 1'b0, 1'b1, 2'b11);
    @(negedge CLK);
    S_VALID = 1'b0;
    @(negedge CLK);
    checks++;
    if (ALU_IN_VALID !== 2'b11 || ALU_OPA !== 8'h11) begin
      errors++;
      $display("FAIL logic9_no_stall: got iv=%b opa=%h, required 11/11", ALU_IN_VALID, ALU_OPA);
    end
  endtask

  task automatic test_fill();
    int  base;
    int  k;
    bit  saw_full;
    bit  ok;
    base = n_push; k = 0; saw_full = 1'b0;
    for (int cyc = 0; cyc < 80 && k < 8; cyc++) begin
      S_VALID = 1'b1;
      S_DATA  = mk(8'(8'h40 + k), 8'(8'h80 + k), 4'(9 + k % 2), 1'b0, 1'b1, 2'b11);
      @(negedge CLK);
      k = n_push - base;
      checks++;
      if (S_READY !== (LEVEL != 3'd4)) begin
        errors++;
        $display("FAIL fill_ready: got ready=%b at level=%0d, required %b",
                 S_READY, LEVEL, LEVEL != 3'd4);
      end
      if (LEVEL == 3'd4) saw_full = 1'b1;
    end
    S_VALID = 1'b0;
    checks++;
    if (!saw_full || k != 8) begin
      errors++;
      $display("FAIL fill_full: got saw_full=%b accepted=%0d, required 1/8", saw_full, k);
    end
    wait_drain(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL fill_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_flush();
    @(negedge CLK);
    S_VALID = 1'b1; S_DATA = mk(8'h01, 8'h02, 4'd9, 1'b0, 1'b1, 2'b11);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      S_DATA = mk(8'(8'hA0 + i), 8'h00, 4'd1, 1'b0, 1'b0, 2'b01);
    end
    @(negedge CLK);
    checks++;
    if (LEVEL !== 3'd3) begin
      errors++;
      $display("FAIL flush_pre_level: got %0d, required 3", LEVEL);
    end
    FLUSH = 1'b1; S_DATA = mk(8'hDD, 8'hDD, 4'd2, 1'b0, 1'b0, 2'b11);
    #1;
    checks++;
    if (S_READY !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready: got %b, required 0", S_READY);
    end
    @(negedge CLK);
    FLUSH = 1'b0; S_VALID = 1'b0;
    sb.delete();
    checks++;
    if (LEVEL !== 3'd0 || ALU_IN_VALID !== 2'b00) begin
      errors++;
      $display("FAIL flush_clear: got level=%0d iv=%b, required 0/00", LEVEL, ALU_IN_VALID);
    end
    repeat (8) @(negedge CLK);
    checks++;
    if (LEVEL !== 3'd0) begin
      errors++;
      $display("FAIL flush_after: got level=%0d, required 0", LEVEL);
    end
  endtask

  task automatic test_reset_mid_stall();
    @(negedge CLK);
    S_VALID = 1'b1; S_DATA = mk(8'h04, 8'h06, 4'd9, 1'b0, 1'b1, 2'b11);
    @(negedge CLK);
    S_DATA = mk(8'h33, 8'h44, 4'd0, 1'b0, 1'b1, 2'b11);
    @(negedge CLK);
    S_VALID = 1'b0;
    #2 RESET_N = 1'b0;
    #1;
    sb.delete();
    checks++;
    if ({ALU_CE, ALU_OPA, ALU_OPB, ALU_CMD, ALU_CIN, ALU_MODE, ALU_IN_VALID, LEVEL, S_READY} !== '0) begin
      errors++;
      $display("FAIL stall_reset_async: got opa=%h iv=%b level=%0d ready=%b, required all 0",
               ALU_OPA, ALU_IN_VALID, LEVEL, S_READY);
    end
    @(negedge CLK);
    RESET_N = 1'b1;
    repeat (6) @(negedge CLK);
    checks++;
    if (LEVEL !== 3'd0 || ALU_IN_VALID !== 2'b00 || ALU_CE !== 1'b1) begin
      errors++;
      $display("FAIL stall_reset_after: got level=%0d iv=%b ce=%b, required 0/00/1",
               LEVEL, ALU_IN_VALID, ALU_CE);
    end
  endtask

`ifdef ISSUE_CNT_EN
  task automatic test_issue_cnt();
    int base;
    int k;
    bit ok;
    @(negedge CLK); FLUSH = 1'b1;
    @(negedge CLK); FLUSH = 1'b0;
    checks++;
    if (ISSUE_CNT !== 16'd0) begin
      errors++;
      $display("FAIL cnt_flush0: got %0d, required 0", ISSUE_CNT);
    end
    base = n_push; k = 0;
    for (int cyc = 0; cyc < 60 && k < 6; cyc++) begin
      S_VALID = 1'b1;
      S_DATA  = (k == 0) ? mk(8'h07, 8'h08, 4'd10, 1'b0, 1'b1, 2'b11)
                         : mk(8'(k), 8'(k), 4'd0, 1'b1, 1'b1, 2'b10);
      @(negedge CLK);
      k = n_push - base;
    end
    S_VALID = 1'b0;
    wait_drain(ok);
    checks++;
    if (!ok || ISSUE_CNT !== 16'd6) begin
      errors++;
      $display("FAIL cnt_six: got %0d drained=%b, required 6/1", ISSUE_CNT, ok);
    end
    @(negedge CLK); FLUSH = 1'b1;
    @(negedge CLK); FLUSH = 1'b0;
    checks++;
    if (ISSUE_CNT !== 16'd0) begin
      errors++;
      $display("FAIL cnt_flush: got %0d, required 0", ISSUE_CNT);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_mul_bubble();
    repeat (4) @(negedge CLK);
    test_fill();
    test_flush();
    test_reset_mid_stall();
`ifdef ISSUE_CNT_EN
    test_issue_cnt();
`endif
    repeat (4) @(negedge CLK);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL final_pending: got %0d, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_queue.md
Name: alu_issue_queue

Overview:
- Upstream feeder for alu_rtl_design.
- Accepts packed ALU commands over a valid/ready handshake and buffers them in a small FIFO.
- Issues one command per cycle onto the ALU input bus, inserting bubbles after multiply commands (MODE=1, CMD=9 or 10) so multi-cycle ALU operations never overlap.
- Replaces direct bench-driven stimulus when the ALU is embedded in a datapath.

Parameters:
- DATA_WIDTH, 8, operand width; matches ALU.
- CMD_WIDTH, 4, command width; matches ALU.
- DEPTH, 4, FIFO entries; power of two, >=2.
- MUL_LAT, 2, bubble cycles inserted after a multiply issue; 0..7.

Ports:
- CLK  in  1  single clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- S_VALID  in  1  upstream command valid.
- S_READY  out  1  queue can accept.
- S_DATA  in  2*DATA_WIDTH+CMD_WIDTH+4  packet; default layout {OPA[23:16], OPB[15:8], CMD[7:4], CIN[3], MODE[2], IN_VALID[1:0]}.
- FLUSH  in  1  synchronous clear of queue and stall.
- ALU_CE  out  1  ALU clock enable.
- ALU_OPA  out  DATA_WIDTH  operand A.
- ALU_OPB  out  DATA_WIDTH  operand B.
- ALU_CMD  out  CMD_WIDTH  command.
- ALU_CIN  out  1  carry in.
- ALU_MODE  out  1  1=arithmetic, 0=logical.
- ALU_IN_VALID  out  2  operand valid bits; 2'b00 = bubble.
- LEVEL  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (RESET_N low, async): FIFO pointers, LEVEL, and all ALU_* outputs cleared to 0; state=IDLE; S_READY=0 while in reset. The first edge after release sets ALU_CE=1 and S_READY=(LEVEL<DEPTH).
- Push: S_VALID && S_READY at an edge writes S_DATA at wptr. S_READY = (LEVEL != DEPTH) && !FLUSH, registered-count based, with no combinational path from S_VALID.
- All ALU_* outputs are registered.
- Issue: at an edge with state=IDLE and LEVEL>0 (LEVEL before that edge), the head entry is loaded into ALU_* and popped.
- Latency: a packet accepted at edge k reaches ALU_* at edge k+1 if the queue was empty and not stalled.
- Back-to-back non-multiply entries issue one per cycle.
- Bubble: no issue at an edge means ALU_IN_VALID<=2'b00; OPA/OPB/CMD/CIN/MODE hold their last values.
- FSM:
  - IDLE: issue when non-empty. If the issued entry has MODE=1 and CMD in {9,10} and MUL_LAT>0, go to STALL with stall_cnt=MUL_LAT-1.
  - STALL: output bubbles; decrement stall_cnt; go to IDLE after the edge where stall_cnt==0. Pushes are still accepted.
- Simultaneous push and pop: LEVEL unchanged. A push and pop in the same cycle at full is legal only as a pop, since S_READY=0 at full.
- Empty: no pop, bubble, LEVEL stays 0.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally; LEVEL disambiguates full from empty.
- FLUSH (synchronous, high): pointers and LEVEL go to 0, state=IDLE, ALU_IN_VALID<=0. A concurrent push is dropped (S_READY=0); a concurrent issue is suppressed. FLUSH has priority over everything except RESET_N.
- Reset mid-stall or mid-burst: all state is lost; no partial issue is emitted afterwards.
- IN_VALID=00 entries are legal and issue as normal (the ALU ignores them); they occupy an issue slot.

Optional Feature:
- ISSUE_CNT_EN:
  - Defined: adds output ISSUE_CNT[15:0], incremented on every non-bubble issue. It wraps 0xFFFF->0, is cleared by reset and FLUSH, and is not incremented on the cycle FLUSH is high.
  - Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package alu_pkg:
  - DATA_WIDTH/CMD_WIDTH defaults and PKT_W.
  - Field offset localparams.
  - CMD codes CMD_MUL_INC=4'd9 and CMD_MUL_SHL=4'd10.
  - State encoding IDLE/STALL.
- Sub-module alu_cmd_fifo (storage, pointers, LEVEL, full/empty). FSM and issue registers stay in alu_issue_queue.

Test Plan:
- Reset, push {OPA=8'h05, OPB=8'h03, CMD=0, CIN=0, MODE=1, IN_VALID=11} -> ALU_OPA=05, ALU_OPB=03, ALU_IN_VALID=11 exactly one edge after acceptance; next cycle bubble (00); LEVEL back to 0.
- Push 4 non-mul packets without issue headroom (hold FIFO full by pushing faster than issue via a 5th S_VALID) -> S_READY=0 at LEVEL=4. The 5th packet is accepted only after a pop; issue order matches push order.
- Push MUL (MODE=1, CMD=9, OPA=8'h04, OPB=8'h06) then ADD (CMD=0) back-to-back with MUL_LAT=2 -> MUL issues at t, bubbles at t+1 and t+2, ADD issues at t+3.
- FLUSH asserted with LEVEL=3 and S_VALID=1 -> next cycle LEVEL=0, ALU_IN_VALID=00, pushed packet not issued later.
- Assert RESET_N=0 asynchronously mid-STALL -> all ALU_* outputs 0 immediately, no pending issue after release.
- With ISSUE_CNT_EN defined, issue 6 packets including one bubble period -> ISSUE_CNT=6; FLUSH -> 0.
